// File: rtl/audio_capture.sv
// audio_capture: four-line I2S receiver that writes 8-channel frames into a circular audio RAM.
// Latency: a word is latched 3 ck cycles after its last sck edge (t); writes occupy t+1..t+4 and frame_done pulses at t+5.
// Backpressure: none; a word that completes while a burst is running is dropped and flagged
// (AUDIO_CAPTURE_OVERRUN_EN defined) or restarts the burst with the new word (macro undefined).
module audio_capture #(
  parameter int BITS        = 16,
  parameter int FRAMES_LOG2 = 5
) (
  input  logic                     ck,
  input  logic                     rst,
  input  logic                     sck,
  input  logic                     ws,
  input  logic [3:0]               sd,
  input  logic                     enable,
  output logic [3+FRAMES_LOG2:0]   waddr,
  output logic [BITS-1:0]          wdata,
  output logic                     we,
  output logic [FRAMES_LOG2-1:0]   frame_ptr,
  output logic                     frame_done,
  output logic                     overrun
);

  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE0 = 3'd1,
    WRITE1 = 3'd2,
    WRITE2 = 3'd3,
    WRITE3 = 3'd4
  } state_t;

  // Synchroniser stages; sck gets a third flop so its rising edge can be detected.
  logic       sck_m, sck_s, sck_d;
  logic       ws_m, ws_s;
  logic [3:0] sd_m, sd_s;

  // Serial capture state.
  logic            ws_prev;
  logic [CW-1:0]   bit_cnt;
  logic [BITS-1:0] shift [4];
  logic [BITS-1:0] word_in [4];

  // Holding registers feeding the write burst.
  logic [BITS-1:0] hold [4];
  logic            side;

  state_t state, state_n;
  logic [1:0] k;
  logic       sck_rise, ws_chg, shift_en, latch, accept, advance;

  // Bring the asynchronous I2S pins into the ck domain.
  always_ff @(posedge ck) begin
    if (!rst) begin
      sck_m <= 1'b0;
      sck_s <= 1'b0;
      sck_d <= 1'b0;
      ws_m  <= 1'b0;
      ws_s  <= 1'b0;
      sd_m  <= 4'd0;
      sd_s  <= 4'd0;
    end else begin
      sck_m <= sck;
      sck_s <= sck_m;
      sck_d <= sck_s;
      ws_m  <= ws;
      ws_s  <= ws_m;
      sd_m  <= sd;
      sd_s  <= sd_m;
    end
  end

  // A ws transition restarts the bit count; the MSB arrives on the next sck edge.
  // bit_cnt parks at BITS so trailing slot bits and post-reset bits are ignored.
  always_comb begin
    sck_rise = sck_s & ~sck_d;
    ws_chg   = sck_rise && (ws_s != ws_prev);
    shift_en = sck_rise && !ws_chg && (bit_cnt < CW'(BITS));
    latch    = shift_en && (bit_cnt == CW'(BITS - 1));
    for (int i = 0; i < 4; i++) begin
      word_in[i] = (shift[i] << 1) | BITS'(sd_s[i]);
    end
  end

  // Shift the four data lines MSB-first on every counted sck rising edge.
  always_ff @(posedge ck) begin
    if (!rst) begin
      ws_prev <= 1'b0;
      bit_cnt <= CW'(BITS);
      for (int i = 0; i < 4; i++) shift[i] <= '0;
    end else if (sck_rise) begin
      ws_prev <= ws_s;
      if (ws_chg) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + CW'(1);
        for (int i = 0; i < 4; i++) shift[i] <= word_in[i];
      end
    end
  end

  // Decide whether a completed word is taken into the holding registers.
`ifdef AUDIO_CAPTURE_OVERRUN_EN
  assign accept = latch && (state == IDLE) && enable;
`else
  assign accept = latch && ((state != IDLE) || enable);
`endif

  // Capture the completed word and its channel side for the write burst.
  always_ff @(posedge ck) begin
    if (!rst) begin
      side <= 1'b0;
      for (int i = 0; i < 4; i++) hold[i] <= '0;
    end else if (accept) begin
      side <= ws_s;
      for (int i = 0; i < 4; i++) hold[i] <= word_in[i];
    end
  end

  // Burst state register.
  always_ff @(posedge ck) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next state and the write port; one line's sample per cycle, chan = 2*k + side.
  always_comb begin
    state_n = state;
    we      = 1'b0;
    k       = 2'd0;
    waddr   = '0;
    wdata   = '0;
    case (state)
      IDLE:    state_n = IDLE;
      WRITE0:  begin state_n = WRITE1; we = 1'b1; k = 2'd0; end
      WRITE1:  begin state_n = WRITE2; we = 1'b1; k = 2'd1; end
      WRITE2:  begin state_n = WRITE3; we = 1'b1; k = 2'd2; end
      WRITE3:  begin state_n = IDLE;   we = 1'b1; k = 2'd3; end
      default: state_n = IDLE;
    endcase
    if (accept) state_n = WRITE0;
    if (we) begin
      waddr = {1'b0, k, side, frame_ptr};
      wdata = hold[k];
    end
  end

  // The right-channel burst closes a frame.
  assign advance = (state == WRITE3) && side;

  // Frame pointer, frame_done pulse one cycle after the last write of a frame.
  always_ff @(posedge ck) begin
    if (!rst) begin
      frame_ptr  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= advance;
      if (advance) frame_ptr <= frame_ptr + FRAMES_LOG2'(1);
    end
  end

`ifdef AUDIO_CAPTURE_OVERRUN_EN
  // Sticky flag for words that completed while a burst was still running.
  always_ff @(posedge ck) begin
    if (!rst)                        overrun <= 1'b0;
    else if (latch && state != IDLE) overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_audio_capture.sv
// tb_audio_capture: randomized I2S frames against a word-level reference model.
// Latency: model predicts ordered RAM writes per completed word; monitor checks them as they appear.
// Backpressure: none; a second BITS=1 instance exercises back-to-back words inside a burst.
module tb_audio_capture;

  logic        ck = 1'b0;
  logic        rst = 1'b0;
  logic        sck = 1'b0, ws = 1'b0;
  logic [3:0]  sd = 4'd0;
  logic        enable = 1'b1;
  logic [8:0]  waddr;
  logic [15:0] wdata;
  logic        we;
  logic [4:0]  frame_ptr;
  logic        frame_done;
  logic        overrun;

  logic        sck_f = 1'b0, ws_f = 1'b0;
  logic [3:0]  sd_f = 4'd0;
  logic [8:0]  waddr_f;
  logic [0:0]  wdata_f;
  logic        we_f;
  logic [4:0]  frame_ptr_f;
  logic        frame_done_f;
  logic        overrun_f;

  audio_capture #(.BITS(16), .FRAMES_LOG2(5)) dut (
    .ck(ck), .rst(rst), .sck(sck), .ws(ws), .sd(sd), .enable(enable),
    .waddr(waddr), .wdata(wdata), .we(we), .frame_ptr(frame_ptr),
    .frame_done(frame_done), .overrun(overrun)
  );

  audio_capture #(.BITS(1), .FRAMES_LOG2(5)) dut_fast (
    .ck(ck), .rst(rst), .sck(sck_f), .ws(ws_f), .sd(sd_f), .enable(1'b1),
    .waddr(waddr_f), .wdata(wdata_f), .we(we_f), .frame_ptr(frame_ptr_f),
    .frame_done(frame_done_f), .overrun(overrun_f)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: expected writes in order, current frame slot, last ws seen by the receiver.
  typedef struct packed {
    logic [8:0]  addr;
    logic [15:0] data;
    logic        last;
  } wr_t;

  wr_t        expq[$];
  logic [4:0] mptr = 5'd0;
  logic       m_ws = 1'b0;
  logic       fd_pend = 1'b0;
  int         we_cnt = 0;
  int         fd_cnt = 0;
  wr_t        e;

  // Monitor: every write must match the model, frame_done only right after a frame's last write.
  always @(negedge ck) begin
    if (rst) begin
      if (fd_pend || frame_done) chk("frame_done", frame_done, fd_pend);
      fd_pend = 1'b0;
      if (frame_done) fd_cnt++;
      if (we) begin
        we_cnt++;
        if (expq.size() == 0) begin
          chk("spurious_we", we, 1'b0);
        end else begin
          e = expq.pop_front();
          chk("waddr", waddr, e.addr);
          chk("wdata", wdata, e.data);
          fd_pend = e.last;
        end
      end
    end
  end

  logic [8:0] fq_addr[$];
  logic [0:0] fq_data[$];

  // Collect writes of the fast instance for a post-hoc comparison.
  always @(negedge ck) begin
    if (rst && we_f) begin
      fq_addr.push_back(waddr_f);
      fq_data.push_back(wdata_f);
    end
  end

  // Model of one completed word: captured only after a ws change and with enable set.
  task automatic model_word(input logic side, input logic [3:0][15:0] v);
    wr_t w;
    for (int k = 0; k < 4; k++) begin
      w.addr = {4'(2 * k + int'(side)), mptr};
      w.data = v[k];
      w.last = side && (k == 3);
      expq.push_back(w);
    end
    if (side) mptr = mptr + 5'd1;
  endtask

  // Drive one I2S word: ws edge, 16 data bits MSB-first, then a few ignored bits.
  task automatic drive_word(input logic side, input logic [3:0][15:0] v);
    int  half  = $urandom_range(1, 3);
    int  extra = $urandom_range(1, 4);
    logic cap  = 1'b0;
    for (int b = 0; b < 17 + extra; b++) begin
      sck = 1'b0;
      ws  = side;
      if (b >= 1 && b <= 16) begin
        for (int k = 0; k < 4; k++) sd[k] = v[k][16 - b];
      end else begin
        sd = 4'($urandom);
      end
      if (b == 0) begin
        cap  = (side != m_ws) && enable;
        m_ws = side;
      end
      repeat (half) @(posedge ck);
      #1 sck = 1'b1;
      if (b == 16 && cap) model_word(side, v);
      repeat (half) @(posedge ck);
      #1;
    end
  endtask

  task automatic rand_vals(output logic [3:0][15:0] v);
    for (int k = 0; k < 4; k++) v[k] = 16'($urandom);
  endtask

  task automatic drive_frame(input logic [3:0][15:0] l, input logic [3:0][15:0] r);
    drive_word(1'b0, l);
    drive_word(1'b1, r);
    repeat (12) @(posedge ck);
    #1;
    chk("frame_ptr", frame_ptr, mptr);
    chk("pending_writes", expq.size(), 0);
  endtask

  task automatic fast_edge(input logic w, input logic [3:0] d);
    sck_f = 1'b0;
    ws_f  = w;
    sd_f  = d;
    @(posedge ck);
    #1 sck_f = 1'b1;
    @(posedge ck);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][15:0] l, r;
    int fd0, we0, n;
    logic [3:0] pat_r, pat_l;
    int exp_n;
    logic exp_ovr;

    // Reset held for 5 cycles: outputs must all be zero.
    repeat (5) @(posedge ck);
    #1;
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_frame_ptr", frame_ptr, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b1;

    // sck activity without any ws change must never write.
    for (int i = 0; i < 40; i++) begin
      sck = ~sck;
      sd  = 4'($urandom);
      repeat (2) @(posedge ck);
      #1;
    end
    sck = 1'b0;
    repeat (6) @(posedge ck);
    #1;
    chk("idle_we_count", we_cnt, 0);

    // Directed frame: known samples on lines 0 and 3.
    rand_vals(l);
    rand_vals(r);
    l[0] = 16'h1111; l[3] = 16'hABCD;
    r[0] = 16'h2222; r[3] = 16'h1234;
    fd0 = fd_cnt;
    drive_frame(l, r);
    chk("first_frame_ptr", frame_ptr, 1);
    chk("first_frame_done", fd_cnt - fd0, 1);

    // 31 more random frames: pointer wraps from 31 back to 0.
    for (int f = 0; f < 31; f++) begin
      rand_vals(l);
      rand_vals(r);
      drive_frame(l, r);
    end
    chk("wrap_frame_ptr", frame_ptr, 0);
    chk("wrap_frame_done", fd_cnt - fd0, 32);

    // Whole frame with enable low: nothing written, pointer held.
    enable = 1'b0;
    we0 = we_cnt;
    fd0 = fd_cnt;
    rand_vals(l);
    rand_vals(r);
    drive_frame(l, r);
    chk("dis_we_count", we_cnt - we0, 0);
    chk("dis_frame_done", fd_cnt - fd0, 0);
    chk("dis_frame_ptr", frame_ptr, 0);

    // Random enable per frame.
    for (int f = 0; f < 6; f++) begin
      enable = 1'($urandom);
      rand_vals(l);
      rand_vals(r);
      drive_frame(l, r);
    end
    enable = 1'b1;

    // Make sure the next left word follows a right word so it is captured.
    rand_vals(r);
    drive_word(1'b1, r);
    repeat (12) @(posedge ck);
    #1;

    // Reset during WRITE1 of a left-word burst.
    rand_vals(l);
    fork
      drive_word(1'b0, l);
      begin
        n = 0;
        do begin
          @(negedge ck);
          n++;
        end while (!we && n < 3000);
        if (!we) begin
          chk("burst_seen", we, 1);
        end else begin
          @(posedge ck);
          #1 rst = 1'b0;
          @(posedge ck);
          #1;
          expq.delete();
          fd_pend = 1'b0;
          mptr = 5'd0;
          m_ws = 1'b0;
          @(negedge ck);
          chk("midrst_we", we, 0);
          chk("midrst_frame_ptr", frame_ptr, 0);
          chk("midrst_overrun", overrun, 0);
          @(posedge ck);
          #1 rst = 1'b1;
        end
      end
    join
    repeat (12) @(posedge ck);
    #1;
    chk("midrst_no_extra", expq.size(), 0);

    // Next left word shows no ws change after reset; only the right word is captured.
    we0 = we_cnt;
    rand_vals(l);
    rand_vals(r);
    drive_frame(l, r);
    chk("post_rst_writes", we_cnt - we0, 4);
    chk("post_rst_frame_ptr", frame_ptr, 1);

    // Fast instance (BITS=1): second word completes while the first burst is in WRITE3.
    pat_r = 4'($urandom);
    pat_l = ~pat_r;
    fq_addr.delete();
    fq_data.delete();
    fast_edge(1'b1, 4'($urandom));
    fast_edge(1'b1, pat_r);
    fast_edge(1'b0, 4'($urandom));
    fast_edge(1'b0, pat_l);
    sck_f = 1'b0;
    repeat (20) @(posedge ck);
    #1;
`ifdef AUDIO_CAPTURE_OVERRUN_EN
    exp_n   = 4;
    exp_ovr = 1'b1;
`else
    exp_n   = 8;
    exp_ovr = 1'b0;
`endif
    chk("fast_overrun", overrun_f, exp_ovr);
    chk("fast_frame_ptr", frame_ptr_f, 1);
    chk("fast_write_count", fq_addr.size(), exp_n);
    for (int i = 0; i < exp_n && i < fq_addr.size(); i++) begin
      if (i < 4) begin
        chk("fast_waddr", fq_addr[i], {4'(2 * i + 1), 5'd0});
        chk("fast_wdata", fq_data[i], pat_r[i]);
      end else begin
        chk("fast_waddr", fq_addr[i], {4'(2 * (i - 4)), 5'd1});
        chk("fast_wdata", fq_data[i], pat_l[i - 4]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
